uart_tx_stimulus: RTL
=====================

UART_TX_STIMULUS -- requirements
Module: uart_tx_stimulus

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port DATA  input  8  byte to transmit.
REQ-006 SHALL have port VALID  input  1  DATA valid; byte accepted on an edge where VALID and READY are both high.
REQ-007 SHALL have port READY  output  1  FIFO can accept a byte.
REQ-008 SHALL have port TXD  output  1  serial line, 8N1, idle high; drives the MCU UART RXD pin.
REQ-009 SHALL have port BUSY  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port LEVEL  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 SHALL drive READY = (LEVEL < FIFO_DEPTH), combinationally from registered occupancy.
REQ-012 SHALL ignore DATA while VALID is low, or while READY is low (no overwrite, no error flag).
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: TXD=1; if FIFO non-empty, SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-015 START: TXD=0 for exactly CLK_DIV cycles, then DATA.
REQ-016 DATA: SHALL send 8 bits LSB first, each held exactly CLK_DIV cycles; a 3-bit bit counter selects the bit; after bit 7, enter STOP.
REQ-017 STOP: TXD=1 for exactly CLK_DIV cycles; at the end, if FIFO non-empty, SHALL pop and enter START directly (no idle gap); else IDLE.
REQ-018 Frame length SHALL be exactly 10*CLK_DIV cycles; the baud counter reloads at every bit boundary with no accumulated drift.
REQ-019 Latency: with FIFO empty and state IDLE, a byte accepted at edge N SHALL drive TXD low starting after edge N+2.
REQ-020 TXD SHALL be a direct register output (glitch-free).
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full = LEVEL==FIFO_DEPTH, empty = LEVEL==0.
REQ-022 Simultaneous push and pop SHALL leave LEVEL unchanged and preserve byte order.
REQ-023 When full, push SHALL be refused even if a pop occurs on the same edge (READY derived from pre-edge LEVEL).
REQ-024 BUSY SHALL be high when state != IDLE or LEVEL != 0.

Reset
REQ-025 On RESET high at an edge: state=IDLE, TXD=1, READY=1, BUSY=0, LEVEL=0, baud and bit counters=0, FIFO pointers=0.
REQ-026 RESET mid-frame SHALL abandon the frame and discard FIFO contents; TXD high from the following cycle.
REQ-027 A VALID asserted in the same cycle as RESET SHALL NOT be accepted.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP), UART_DATA_BITS=8, and UART_STOP_BITS=1.
REQ-029 FIFO SHALL be a sub-module uart_tx_fifo (sync, registered LEVEL, parameter FIFO_DEPTH); the FSM, baud counter and shift register stay in uart_tx_stimulus.
REQ-030 Baud counter width SHALL be clog2(CLK_DIV).

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 Single byte 0xA5 pushed while idle -> TXD low after edge N+2; sampled mid-bit: 0,1,0,1,0,0,1,0,1,1; BUSY falls 40 cycles after start.
REQ-032 Push 0x11,0x22,0x33,0x44 back-to-back -> READY low after 4th push; 4 contiguous frames, 160 cycles, no idle gap; bytes in order.
REQ-033 FIFO full, VALID held with 0x55 across the pop edge -> 0x55 not accepted that edge, accepted the next edge; LEVEL never exceeds 4.
REQ-034 RESET asserted at cycle 17 of a 0x0F frame -> TXD=1, LEVEL=0, BUSY=0 next cycle; no further falling edge without a new push.
REQ-035 Loopback into the existing UART capture model at matching baud -> 0x48,0x69,0x0A printed as "Hi" newline.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing constants and transmitter state encoding.
// Frame is 8N1: one start bit, UART_DATA_BITS data bits, UART_STOP_BITS stop bit.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous byte FIFO with registered occupancy for the UART transmitter.
// Latency: a pushed byte is visible at head_dat and counted in level after one edge.
// Backpressure: pushes are dropped when level==FIFO_DEPTH before the edge; pops when empty are ignored.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    push_dat,
  input  logic                          pop,
  output logic [7:0]                    head_dat,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the pre-edge level, so a pop never frees room for a same-edge push.
  assign do_push  = push && (level < DEPTH_L);
  assign do_pop   = pop && (level != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stimulus.sv
// Purpose: buffered 8N1 UART transmitter driving an MCU RXD pin from a byte valid/ready stream.
// Latency: byte accepted at edge N drives the start bit from edge N+2; frames are 10*CLK_DIV cycles, back to back.
// Backpressure: READY drops when the FIFO holds FIFO_DEPTH bytes; bytes offered while READY is low are ignored.
module uart_tx_stimulus #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    DATA,
  input  logic                          VALID,
  output logic                          READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  import uart_pkg::*;

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [$clog2(FIFO_DEPTH):0] DEPTH_L = FIFO_DEPTH[$clog2(FIFO_DEPTH):0];

  uart_state_t   state_q;
  uart_state_t   state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          txd_d;
  logic          pop;
  logic          push;
  logic [7:0]    head;
  logic          fifo_empty;
  logic          baud_end;

  assign READY      = (LEVEL < DEPTH_L);
  assign push       = VALID && READY && !RESET;
  assign fifo_empty = (LEVEL == '0);
  assign BUSY       = (state_q != IDLE) || !fifo_empty;
  assign baud_end   = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .reset    (RESET),
    .push     (push),
    .push_dat (DATA),
    .pop      (pop),
    .head_dat (head),
    .level    (LEVEL)
  );

  // TXD is registered from the current state, so the line trails the state by one cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          state_d = uart_pkg::DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      uart_pkg::DATA: begin
        txd_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      TXD     <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      TXD     <= txd_d;
    end
  end

endmodule
